// File: rtl/fifo_wr_arb_ctrl_if.sv
// Request/grant, RAM strobe/address and status bundle for fifo_wr_arb_ctrl.
// The master side issues requests; the slave side is the controller.
interface fifo_wr_arb_ctrl_if #(
   parameter int AW = 4
);
   logic          wr0;
   logic          wr1;
   logic          rd;
   logic          err_clr;
   logic          gnt0;
   logic          gnt1;
   logic          wr_sel;
   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic          ovf_err;
   logic          udf_err;

   modport master (
      output wr0, wr1, rd, err_clr,
      input  gnt0, gnt1, wr_sel, wr_en, rd_en, wr_addr, rd_addr, count,
             full, empty, almost_full, almost_empty, ovf_err, udf_err
   );

   modport slave (
      input  wr0, wr1, rd, err_clr,
      output gnt0, gnt1, wr_sel, wr_en, rd_en, wr_addr, rd_addr, count,
             full, empty, almost_full, almost_empty, ovf_err, udf_err
   );
endinterface

// File: rtl/fifo_wr_arb_ctrl.sv
// Pointer/count/flag control for a single-clock FIFO whose write port is shared by two
// producers under round-robin arbitration. Sticky error flags are built only with FIFO_ERR_FLAGS_EN.
module fifo_wr_arb_ctrl #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2
) (
   input logic               clk,
   input logic               rst,
   fifo_wr_arb_ctrl_if.slave bus
);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   AF_C    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0]   AE_C    = (AW+1)'(AE_THRESH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);
   localparam logic [AW-1:0] ADR_ONE = AW'(1);

   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [AW:0]   count_q, count_d;
   logic          lg_q, lg_d;
   logic          full, empty, wr_req, sel, wr_en, rd_en;

   assign full   = (count_q == DEPTH_C);
   assign empty  = (count_q == '0);
   assign wr_req = bus.wr0 | bus.wr1;

   // On a tie the producer that did not win last time is chosen.
   always_comb begin
      sel = bus.wr1;
      if (bus.wr0 && bus.wr1) sel = ~lg_q;
   end

   // Nothing is accepted while reset is held.
   assign wr_en = rst & wr_req & ~full;
   assign rd_en = rst & bus.rd & ~empty;

   always_comb begin
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
      lg_d      = lg_q;
      count_d   = count_q;
      if (wr_en) begin
         wr_addr_d = (wr_addr_q == LAST_C) ? '0 : wr_addr_q + ADR_ONE;
         lg_d      = sel;
      end
      if (rd_en) rd_addr_d = (rd_addr_q == LAST_C) ? '0 : rd_addr_q + ADR_ONE;
      if (wr_en && !rd_en)      count_d = count_q + CNT_ONE;
      else if (!wr_en && rd_en) count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         count_q   <= '0;
         lg_q      <= 1'b1;
      end else begin
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         count_q   <= count_d;
         lg_q      <= lg_d;
      end
   end

   assign bus.wr_en        = wr_en;
   assign bus.rd_en        = rd_en;
   assign bus.wr_sel       = sel;
   assign bus.gnt0         = wr_en & ~sel;
   assign bus.gnt1         = wr_en & sel;
   assign bus.wr_addr      = wr_addr_q;
   assign bus.rd_addr      = rd_addr_q;
   assign bus.count        = count_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= AF_C);
   assign bus.almost_empty = (count_q <= AE_C);

`ifdef FIFO_ERR_FLAGS_EN
   logic ovf_q, ovf_d, udf_q, udf_d;

   // A set condition on the same edge as err_clr wins over the clear.
   assign ovf_d = (wr_req & full) | (ovf_q & ~bus.err_clr);
   assign udf_d = (bus.rd & empty) | (udf_q & ~bus.err_clr);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign bus.ovf_err = ovf_q;
   assign bus.udf_err = udf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.ovf_err    = 1'b0;
   assign bus.udf_err    = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Scoreboard bench for fifo_wr_arb_ctrl: a queue-based FIFO model predicts every cycle's
// outputs, which a separate negedge monitor compares against the DUT.
module tb_fifo_wr_arb_ctrl;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int AF    = 3;
   localparam int AE    = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fifo_wr_arb_ctrl_if #(.AW(AW)) bus ();

   fifo_wr_arb_ctrl #(
      .DEPTH(DEPTH), .AW(AW), .AF_THRESH(AF), .AE_THRESH(AE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] exp_q[$];

   // Model state: the FIFO is a queue of the RAM addresses currently holding data.
   int m_q[$];
   int m_wr;
   int m_lg;
   bit m_ovf;
   bit m_udf;

   function automatic logic [31:0] pack(
      input logic g0, g1, sel, we, re,
      input logic [AW-1:0] wa, ra,
      input logic [AW:0] cnt,
      input logic fl, em, af, ae, ov, ud);
      return {14'd0, g0, g1, (we ? sel : 1'b0), we, re, wa, ra, cnt, fl, em, af, ae, ov, ud};
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_wr  = 0;
      m_lg  = 1;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic step(input bit r, input bit w0, input bit w1, input bit rdq, input bit clr);
      int cnt, ra;
      bit fl, em, sel, we, re;
      @(posedge clk);
      #1;
      rst         = r;
      bus.wr0     = w0;
      bus.wr1     = w1;
      bus.rd      = rdq;
      bus.err_clr = clr;
      if (!r) model_reset();
      cnt = m_q.size();
      fl  = (cnt == DEPTH);
      em  = (cnt == 0);
      sel = (w0 && w1) ? (m_lg == 0) : w1;
      we  = r && (w0 || w1) && !fl;
      re  = r && rdq && !em;
      ra  = em ? m_wr : m_q[0];
      exp_q.push_back(pack(we && !sel, we && sel, sel, we, re, AW'(m_wr), AW'(ra),
                           (AW+1)'(cnt), fl, em, cnt >= AF, cnt <= AE, m_ovf, m_udf));
      if (r) begin
`ifdef FIFO_ERR_FLAGS_EN
         m_ovf = ((w0 || w1) && fl) || (m_ovf && !clr);
         m_udf = (rdq && em) || (m_udf && !clr);
`endif
         if (re) void'(m_q.pop_front());
         if (we) begin
            m_q.push_back(m_wr);
            m_wr = (m_wr + 1) % DEPTH;
            m_lg = sel;
         end
      end
   endtask

   initial begin : monitor
      logic [31:0] e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = pack(bus.gnt0, bus.gnt1, bus.wr_sel, bus.wr_en, bus.rd_en, bus.wr_addr,
                     bus.rd_addr, bus.count, bus.full, bus.empty, bus.almost_full,
                     bus.almost_empty, bus.ovf_err, bus.udf_err);
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL vec%0d t=%0t: dut=%05h expected=%05h (g0 g1 sel we re wa ra cnt f e af ae ov ud)",
                        vectors, $time, a, e);
            end
         end
      end
   end

   initial begin
      int pw0, pw1, prd;
      bus.wr0     = 1'b0;
      bus.wr1     = 1'b0;
      bus.rd      = 1'b0;
      bus.err_clr = 1'b0;
      model_reset();

      repeat (2) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      repeat (5) step(1, 1, 0, 0, 0);
      repeat (3) step(1, 0, 0, 1, 0);
      repeat (6) step(1, 1, 1, 1, 0);
      repeat (4) step(1, 0, 1, 0, 0);
      step(1, 0, 1, 1, 0);
      step(1, 0, 1, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      repeat (5) step(1, 0, 0, 1, 0);
      step(1, 1, 0, 1, 0);
      step(1, 0, 0, 0, 1);
      repeat (3) step(1, 1, 1, 0, 0);
      step(0, 1, 1, 1, 0);
      step(1, 1, 1, 0, 0);

      for (int seg = 0; seg < 8; seg++) begin
         pw0 = $urandom_range(10, 90);
         pw1 = $urandom_range(10, 90);
         prd = $urandom_range(10, 90);
         for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 59) != 0,
                 $urandom_range(0, 99) < pw0,
                 $urandom_range(0, 99) < pw1,
                 $urandom_range(0, 99) < prd,
                 $urandom_range(0, 7) == 0);
         end
      end

      @(negedge clk);
      @(negedge clk);
      #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arb_ctrl.md
Name: fifo_wr_arb_ctrl

Overview:
- Control block for a single-clock FIFO whose write port is shared by two producers.
- Round-robin arbitration picks one producer per cycle for the single write port.
- Keeps the write and read addresses, the occupancy count, and the full, empty and almost-full/almost-empty flags.
- Drives the write/read strobes and addresses of an external RAM and the producer data mux select; holds no data itself.

Parameters:
- DEPTH, 16, number of FIFO entries; any value >= 2, need not be a power of 2.
- AW, 4, address width; must satisfy 2**AW >= DEPTH.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- wr0  in  1  producer 0 write request.
- wr1  in  1  producer 1 write request.
- rd  in  1  consumer read request.
- gnt0  out  1  producer 0 write accepted this cycle.
- gnt1  out  1  producer 1 write accepted this cycle.
- wr_sel  out  1  data mux select: 0 = producer 0, 1 = producer 1; valid when wr_en = 1.
- wr_en  out  1  RAM write strobe.
- rd_en  out  1  RAM read strobe (read accepted).
- wr_addr  out  AW  RAM write address.
- rd_addr  out  AW  RAM read address.
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- ovf_err  out  1  sticky overflow error (see Optional Feature).
- udf_err  out  1  sticky underflow error (see Optional Feature).
- err_clr  in  1  clears ovf_err and udf_err.

Behaviour:
- Reset (rst = 0, asynchronous):
  - wr_addr = 0, rd_addr = 0, count = 0.
  - last-grant register lg = 1, so producer 0 wins the first tie.
  - Error flags = 0.
  - Resulting outputs: empty = 1, almost_empty = 1, full = 0, almost_full = 0 (almost_full = 1 only if AF_THRESH = 0).
  - A reset mid-operation discards all pending state immediately; no request is accepted while rst = 0.
- All flags decode combinationally from the registered count; no extra latency.
- Write acceptance (combinational, same cycle):
  - wr_en = (wr0 | wr1) & ~full.
  - One request only: that requester is granted.
  - Both requesting: grant goes to the requester not equal to lg.
  - wr_sel = granted index; gnt0/gnt1 = wr_en & (wr_sel == 0/1).
  - gnt0 and gnt1 are never both 1.
- Arbitration state: lg updates to wr_sel on every clock edge where wr_en = 1; otherwise it holds.
- Read acceptance: rd_en = rd & ~empty, combinational. rd_addr is the address of the word being popped; the RAM returns data per its own latency.
- On each clock edge:
  - wr_en = 1: wr_addr advances by 1, wrapping DEPTH-1 -> 0.
  - rd_en = 1: rd_addr advances by 1, wrapping DEPTH-1 -> 0.
  - count: +1 on write only, -1 on read only, unchanged when both or neither.
- Boundary cases:
  - Full with write + read in the same cycle: write refused (no bypass), read accepted; count goes DEPTH -> DEPTH-1.
  - Empty with write + read in the same cycle: read refused, write accepted; count goes 0 -> 1.
  - Requests while full: gnt0 = gnt1 = 0 and lg holds, so fairness is preserved across stalls.
  - count never leaves the range 0..DEPTH.
  - With non-power-of-2 DEPTH, addresses must never reach DEPTH.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - ovf_err is set on any clock edge where (wr0 | wr1) & full.
  - udf_err is set on any clock edge where rd & empty.
  - Both flags are sticky until err_clr = 1 at a clock edge or reset.
  - If err_clr and a set condition occur together, the set wins.
- Undefined: ovf_err and udf_err are tied to 0, err_clr is ignored, and no error registers exist.

Test Plan:
- Reset then idle, DEPTH = 4, AF = 3, AE = 1 -> count = 0, empty = 1, almost_empty = 1, full = 0, both addresses 0.
- wr0 alone for 4 cycles -> gnt0 each cycle; wr_addr 0, 1, 2, 3 then wraps to 0; count 4; full = 1; almost_full asserted from count 3.
- wr0 = wr1 = 1 held with rd = 1 every cycle from count 1 -> grants alternate 0, 1, 0, 1 (producer 0 first after reset); count stays 1.
- Full (count 4) with wr1 = 1 and rd = 1 -> wr_en = 0, rd_en = 1, count 3; next cycle wr1 is granted, count 4.
- Empty with wr0 = 1 and rd = 1 -> rd_en = 0, wr_en = 1, count 1; rd_addr unchanged.
- Macro defined: wr0 while full -> ovf_err = 1 and stays 1; err_clr pulse -> 0. rd while empty -> udf_err = 1. Reset asserted mid-burst -> all state cleared in the same cycle.
